calc_dec: RTL and testbench
===========================

# calc_dec

Command-to-button decoder for the calculator: the inverse of the button encoder. It accepts a 4-bit ALU opcode over a valid/ready handshake and converts it back to the btnl/btnc/btnr button combination that the encoder maps to that opcode. It then replays a timed press: buttons held, then a btnd accumulate strobe, then release. It sits in front of the calculator's button inputs for scripted self-test and automated operation, so no human has to press buttons.

## Interface
- HOLD_CYCLES, 4: cycles the buttons are driven before the strobe (1..65535)
- STROBE_CYCLES, 1: cycles btnd is held high (1..65535)
- GAP_CYCLES, 2: cycles all buttons are low after the strobe, before the next command (1..65535)

- clk  input  1  system clock, rising-edge
- btnu  input  1  reset, synchronous, active-high
- cmd_valid  input  1  cmd_op is valid this cycle
- cmd_op  input  4  requested ALU opcode
- cmd_ready  output  1  block can accept a command this cycle
- btnl  output  1  decoded left button level
- btnc  output  1  decoded centre button level
- btnr  output  1  decoded right button level
- btnd  output  1  accumulate strobe
- busy  output  1  press sequence in progress
- err  output  1  one-cycle pulse: rejected (unencodable) opcode
- done  output  1  one-cycle pulse: press sequence completed

## Operation
- Decode table, cmd_op -> {btnl,btnc,btnr}:
  - 0000->000, 0001->001, 0010->010, 0110->011
  - 0100->100, 1001->101, 1010->110, 0101->111
- Any other opcode is invalid. The invalid set is 0011, 0111, 1000, 1011, 1100, 1101, 1110, 1111.
- FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE -> SETUP on handshake with a valid code. Decoded buttons are registered and the counter is loaded.
  - IDLE stays IDLE on handshake with an invalid code. err pulses; buttons stay 0.
  - SETUP -> STROBE after HOLD_CYCLES cycles.
  - STROBE -> GAP after STROBE_CYCLES cycles.
  - GAP -> IDLE after GAP_CYCLES cycles. done pulses in the first IDLE cycle.
- Outputs by state:
  - SETUP: buttons = decoded value, btnd = 0.
  - STROBE: buttons unchanged, btnd = 1.
  - GAP: all buttons and btnd = 0.
  - IDLE: all buttons and btnd = 0.
- Opcode 0000 is valid and runs the full sequence with all three buttons low.
- cmd_ready = (state == IDLE) and not btnu. Commands offered while not ready are ignored, not queued.
- busy = (state != IDLE).
- Single down-counter, 16 bits wide, shared by all timed states. It is loaded with N-1 on entry to each state, and the state advances when the counter reaches 0.

## Timing
- Reset values, with btnu high at an edge: state IDLE; btnl/btnc/btnr/btnd/busy/err/done = 0; counter = 0. cmd_ready = 0 while btnu is high and 1 in the first cycle after release.
- Handshake: a command is accepted at rising edge T when cmd_valid and cmd_ready are both high.
  - Valid code: from T+1, busy = 1 and buttons = decoded value for HOLD_CYCLES cycles.
  - btnd is high for cycles T+1+HOLD_CYCLES .. T+HOLD_CYCLES+STROBE_CYCLES.
  - Then GAP_CYCLES cycles with everything low.
  - IDLE (cmd_ready = 1, done = 1) at cycle T+1+HOLD_CYCLES+STROBE_CYCLES+GAP_CYCLES.
- Defaults give a total busy time of 7 cycles; the next accept is possible at the done cycle.
- Invalid code accepted at T: err = 1 during cycle T+1 only. State stays IDLE, cmd_ready stays 1, and a new command is accepted at T+1.
- Buttons never change while btnd is high. Buttons are stable for at least HOLD_CYCLES cycles before the btnd rising edge and remain stable through its falling edge.
- Back-to-back commands (cmd_valid held high): the GAP separation is always enforced; no command is accepted while busy.
- Reset mid-sequence: at the edge where btnu is sampled high, every output is 0 and the state is IDLE. The interrupted command is dropped and done is not pulsed.
- done and err are never high in the same cycle.

## Test plan
- Reset: hold btnu 3 cycles from an arbitrary state -> all outputs 0 and cmd_ready 0 during reset; cmd_ready = 1 in the first cycle after btnu falls.
- Round trip: issue each of the 8 valid codes through a reference calc_enc model -> the button levels sampled while btnd = 1 re-encode to the issued cmd_op. Example: 1010 -> btnl = 1, btnc = 1, btnr = 0.
- Exact timing with defaults: accept 0110 at edge T -> {btnc, btnr} = 11 for cycles T+1..T+4, btnd = 1 at T+5, all low at T+6..T+7, done = 1 and cmd_ready = 1 at T+8.
- Invalid code: offer 1100 -> err = 1 for one cycle, no button or btnd activity, cmd_ready stays 1. A following 0001 is accepted on the next cycle.
- Back-to-back: hold cmd_valid high with 0001 then 1001 -> exactly 2 strobes, with ≥2 all-low cycles between the btnd pulses and no command lost or duplicated.
- Reset during STROBE: assert btnu while btnd = 1 -> outputs 0 at the next edge, no done pulse, and a fresh command after reset runs the full sequence normally.

Source files
------------

// File: rtl/calc_dec_if.sv
// Command handshake between a scripted controller (master) and the
// button-press decoder (slave).
interface calc_dec_if;
  logic       cmd_valid;
  logic [3:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/calc_dec.sv
// Turns an ALU opcode back into the btnl/btnc/btnr combination that encodes it
// and replays a timed press: hold, btnd strobe, then an all-low gap.
module calc_dec #(
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned STROBE_CYCLES = 1,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic           clk,
  input  logic           btnu,
  calc_dec_if.slave      cmd,
  output logic           btnl,
  output logic           btnc,
  output logic           btnr,
  output logic           btnd,
  output logic           busy,
  output logic           err,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STROBE_LOAD = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  btn_q, btn_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        dec_valid;
  logic [2:0]  dec_btn;
  logic        accept;

  // Inverse of the button encoder; unlisted opcodes have no button combination.
  always_comb begin
    dec_valid = 1'b1;
    dec_btn   = 3'b000;
    unique case (cmd.cmd_op)
      4'b0000: dec_btn = 3'b000;
      4'b0001: dec_btn = 3'b001;
      4'b0010: dec_btn = 3'b010;
      4'b0110: dec_btn = 3'b011;
      4'b0100: dec_btn = 3'b100;
      4'b1001: dec_btn = 3'b101;
      4'b1010: dec_btn = 3'b110;
      4'b0101: dec_btn = 3'b111;
      default: dec_valid = 1'b0;
    endcase
  end

  assign cmd.cmd_ready = (state_q == IDLE) && !btnu;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = btn_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_valid) begin
            state_d = SETUP;
            cnt_d   = HOLD_LOAD;
            btn_d   = dec_btn;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          btn_d   = 3'b000;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (btnu) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 3'b000;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // btn_q is only non-zero during SETUP and STROBE, so it drives the pins directly.
  assign {btnl, btnc, btnr} = btn_q;
  assign btnd = (state_q == STROBE);
  assign busy = (state_q != IDLE);
  assign err  = err_q;
  assign done = done_q;

endmodule

// File: tb/tb_calc_dec.sv
// Randomised scoreboard bench for calc_dec: a timeline model predicts outputs
// per cycle and an event queue predicts err/strobe/done pulses.
module tb_calc_dec;
  localparam int H = 4;
  localparam int S = 1;
  localparam int G = 2;

  logic clk  = 1'b0;
  logic btnu = 1'b1;
  logic btnl, btnc, btnr, btnd, busy, err, done;

  calc_dec_if cmd_bus ();

  calc_dec #(
    .HOLD_CYCLES  (H),
    .STROBE_CYCLES(S),
    .GAP_CYCLES   (G)
  ) dut (
    .clk (clk),
    .btnu(btnu),
    .cmd (cmd_bus.slave),
    .btnl(btnl),
    .btnc(btnc),
    .btnr(btnr),
    .btnd(btnd),
    .busy(busy),
    .err (err),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_ERR, EV_PRESS, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [3:0] op;
  } ev_t;

  int         checks = 0;
  int         errors = 0;
  ev_t        exp_q[$];
  logic [4:0] exp_map[int];   // {busy, btnl, btnc, btnr, btnd} per cycle
  logic       exp_ready = 1'b0;
  int         ready_from = 0;
  logic       prev_btnd = 1'b0;
  logic [4:0] mon_exp;

  // Reference button encoder: button combination -> opcode.
  function automatic logic [3:0] enc(input logic [2:0] b);
    case (b)
      3'b000:  return 4'b0000;
      3'b001:  return 4'b0001;
      3'b010:  return 4'b0010;
      3'b011:  return 4'b0110;
      3'b100:  return 4'b0100;
      3'b101:  return 4'b1001;
      3'b110:  return 4'b1010;
      default: return 4'b0101;
    endcase
  endfunction

  function automatic bit decode(input logic [3:0] op, output logic [2:0] b);
    b = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (enc(3'(i)) == op) begin
        b = 3'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the DUT must do in response.
  task automatic step(input logic v, input logic [3:0] op, input logic rst, output bit acc);
    int         cur, t;
    logic [2:0] b;
    cur = cyc;
    acc = 1'b0;
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    btnu              = rst;
    exp_ready         = !rst && (cur >= ready_from);
    if (rst) begin
      t = cur + 1;
      for (int c = t; c <= t + H + S + G; c++)
        if (exp_map.exists(c)) exp_map.delete(c);
      while (exp_q.size() > 0 && exp_q[$].cyc >= t) void'(exp_q.pop_back());
      ready_from = t;
    end else if (exp_ready && v) begin
      t   = cur + 1;
      acc = 1'b1;
      if (decode(op, b)) begin
        for (int i = 0; i < H + S + G; i++)
          exp_map[t + i] = (i < H)     ? {1'b1, b, 1'b0} :
                           (i < H + S) ? {1'b1, b, 1'b1} : 5'b10000;
        exp_q.push_back('{EV_PRESS, t + H, op});
        exp_q.push_back('{EV_DONE, t + H + S + G, op});
        ready_from = t + H + S + G;
      end else begin
        exp_q.push_back('{EV_ERR, t, op});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 4'h0, 1'b0, acc);
  endtask

  // Hold cmd_valid with op until the model says it was taken; t = accept edge.
  task automatic offer(input logic [3:0] op, output int t);
    bit acc;
    for (int i = 0; i < 40; i++) begin
      t = cyc + 1;
      step(1'b1, op, 1'b0, acc);
      if (acc) return;
    end
    t = -1;
  endtask

  task automatic expect_event(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event cycle=%0d got=%0d want=none", cyc, k);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(k), 32'(e.kind));
      check("event_cycle", cyc, e.cyc);
      if (k == EV_PRESS)
        check("press_roundtrip", {28'd0, enc({btnl, btnc, btnr})}, {28'd0, e.op});
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mon_exp = exp_map.exists(cyc) ? exp_map[cyc] : 5'b00000;
      check("outputs", {busy, btnl, btnc, btnr, btnd}, mon_exp);
      check("cmd_ready", cmd_bus.cmd_ready, exp_ready);
      check("err_done_exclusive", err & done, 1'b0);
      if (err === 1'b1) expect_event(EV_ERR);
      if (btnd === 1'b1 && prev_btnd !== 1'b1) expect_event(EV_PRESS);
      if (done === 1'b1) expect_event(EV_DONE);
    end
    prev_btnd = btnd;
  end

  initial begin
    bit         acc;
    int         t;
    logic [3:0] codes[8];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b1001, 4'b1010, 4'b0101};
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 4'h0;
    btnu              = 1'b1;
    @(posedge clk);
    #1;
    // Reset held for three edges with a command offered that must be ignored.
    repeat (2) step(1'b1, 4'b0001, 1'b1, acc);

    // Exact timing of a single press.
    step(1'b1, 4'b0110, 1'b0, acc);
    idle(9);

    // Rejected opcode, then a valid one on the very next cycle.
    step(1'b1, 4'b1100, 1'b0, acc);
    step(1'b1, 4'b0001, 1'b0, acc);
    idle(9);

    // Back-to-back with cmd_valid held high.
    offer(4'b0001, t);
    offer(4'b1001, t);
    idle(10);

    // Round trip of every valid code.
    foreach (codes[i]) begin
      offer(codes[i], t);
      idle($urandom_range(0, 3));
    end
    idle(8);

    // Reset while btnd is high, then a fresh command.
    offer(4'b0101, t);
    for (int i = 0; i < 20 && cyc < t + H; i++) step(1'b0, 4'h0, 1'b0, acc);
    repeat (3) step(1'b0, 4'h0, 1'b1, acc);
    offer(4'b1001, t);
    idle(10);

    // Random traffic with occasional resets.
    repeat (400)
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 59) == 0, acc);
    idle(12);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
